sdrc_burst_addr_seq: RTL and testbench

- Sequences the 13-bit address incrementer used by the SDRAM transfer controller.
- Accepts one burst request: start address plus beat count. Emits one address per accepted beat.
- Detects column/page boundaries from cfg_colbits. At a boundary it stalls for a row re-open handshake before continuing.
- Sits between the transfer request queue and the command/datapath stage of the SDRAM controller.

---
 rtl/sdrc_burst_addr_seq.sv | 169 ++++++++++++++++
 tb/tb_sdrc_burst_addr_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_burst_addr_seq.sv
// Burst address sequencer for the SDRAM transfer controller.
// Takes one burst request (start address + beat count) and issues one
// address per accepted beat. When a beat leaves the last column of a page,
// it waits for a row re-open handshake (pg_req/pg_ack) before continuing.
module sdrc_burst_addr_seq #(
  parameter int AW = 13,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    cfg_colbits,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  output logic          beat_valid,
  input  logic          beat_ready,
  output logic [AW-1:0] beat_addr,
  output logic          beat_last,
  output logic          pg_req,
  input  logic          pg_ack,
  input  logic          abort,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PGWAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [1:0]    colbits_q, colbits_d;
  logic          done_q, done_d;

  logic          xfer_s;
  logic          last_s;
  logic          col_end_s;

  // True when the column field of a (8..11 bits wide) is all ones.
  function automatic logic col_at_end(input logic [AW-1:0] a, input logic [1:0] cb);
    logic [AW-1:0] mask;
    case (cb)
      2'b00:   mask = AW'(11'h0FF);
      2'b01:   mask = AW'(11'h1FF);
      2'b10:   mask = AW'(11'h3FF);
      2'b11:   mask = AW'(11'h7FF);
      default: mask = AW'(11'h0FF);
    endcase
    return ((a & mask) == mask);
  endfunction

  assign xfer_s    = (state_q == S_RUN) && beat_ready;
  assign last_s    = (rem_q == LW'(1));
  assign col_end_s = col_at_end(addr_q, colbits_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= {AW{1'b0}};
      rem_q     <= {LW{1'b0}};
      colbits_q <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      colbits_q <= colbits_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update; abort outranks completion and page waits.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    colbits_d = colbits_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          rem_d     = req_len;
          colbits_d = cfg_colbits;
          if (req_len == {LW{1'b0}}) begin
            // Empty burst: nothing to issue, just report completion.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (xfer_s) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
        end else begin
          addr_d = addr_q;
          rem_d  = rem_q;
        end
        if (abort) begin
          state_d = S_IDLE;
          rem_d   = {LW{1'b0}};
          done_d  = 1'b1;
        end else if (xfer_s && last_s) begin
          // Final beat wins over a page crossing on the same beat.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (xfer_s && col_end_s) begin
          state_d = S_PGWAIT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PGWAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          rem_d   = {LW{1'b0}};
          done_d  = 1'b1;
        end else if (pg_ack) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PGWAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = {LW{1'b0}};
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    req_ready  = 1'b0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    pg_req     = 1'b0;
    busy       = 1'b0;
    beat_addr  = addr_q;
    done       = done_q;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_RUN: begin
        beat_valid = 1'b1;
        beat_last  = last_s;
        busy       = 1'b1;
      end
      S_PGWAIT: begin
        pg_req = 1'b1;
        busy   = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdrc_burst_addr_seq.sv
// Directed bench for sdrc_burst_addr_seq: a per-cycle vector table plus
// hand-written sequences for toggled-ready abort and async reset.
module tb_sdrc_burst_addr_seq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  cfg_colbits;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_addr;
  logic [7:0]  req_len;
  logic        beat_valid;
  logic        beat_ready;
  logic [12:0] beat_addr;
  logic        beat_last;
  logic        pg_req;
  logic        pg_ack;
  logic        abort;
  logic        busy;
  logic        done;

  sdrc_burst_addr_seq #(.AW(13), .LW(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_colbits(cfg_colbits),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_addr(beat_addr), .beat_last(beat_last), .pg_req(pg_req),
    .pg_ack(pg_ack), .abort(abort), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags order: {req_ready, beat_valid, beat_last, pg_req, busy, done}
  localparam logic [5:0] F_IDLE = 6'b100000;
  localparam logic [5:0] F_RUN  = 6'b010010;
  localparam logic [5:0] F_RUNL = 6'b011010;
  localparam logic [5:0] F_PGW  = 6'b000110;
  localparam logic [5:0] F_DONE = 6'b100001;

  typedef struct {
    logic        rv;
    logic [12:0] ra;
    logic [7:0]  rl;
    logic [1:0]  cb;
    logic        br;
    logic        pa;
    logic        ab;
    logic [5:0]  ef;
    logic        ca;
    logic [12:0] ea;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  // Count beat transfers and done pulses as seen at each rising edge.
  always @(posedge clk) begin
    if (beat_valid && beat_ready) xfer_cnt++;
    if (done) done_cnt++;
  end

  function automatic vec_t mk(input logic rv, input logic [12:0] ra, input logic [7:0] rl,
                              input logic [1:0] cb, input logic br, input logic pa,
                              input logic ab, input logic [5:0] ef, input logic ca,
                              input logic [12:0] ea);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rl = rl; v.cb = cb; v.br = br; v.pa = pa; v.ab = ab;
    v.ef = ef; v.ca = ca; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid   = v.rv;
    req_addr    = v.ra;
    req_len     = v.rl;
    cfg_colbits = v.cb;
    beat_ready  = v.br;
    pg_ack      = v.pa;
    abort       = v.ab;
  endtask

  initial begin
    int cyc;
    logic ph;
    reset_n = 1'b0;
    drive(mk(1'b0, 13'h0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    #12 reset_n = 1'b1;

    // Reset state
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b1, 13'h0000));
    // Plain 4-beat burst at 0x010
    vq.push_back(mk(1'b1, 13'h010, 8'd4, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h010));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h011));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h012));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUNL, 1'b1, 13'h013));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b1, 1'b0, F_DONE, 1'b0, 13'h0));
    // pg_ack in IDLE is ignored
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    // Page crossing at 0x0FF, ack after 3 wait cycles
    vq.push_back(mk(1'b1, 13'h0FE, 8'd4, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h0FE));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h0FF));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_PGW,  1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_PGW,  1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b1, 1'b0, F_PGW,  1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h100));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUNL, 1'b1, 13'h101));
    // Accept while done is high: 0x1FFF wraps to 0x0000 with colbits=11
    vq.push_back(mk(1'b1, 13'h1FFF, 8'd2, 2'b11, 1'b0, 1'b0, 1'b0, F_DONE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h1FFF));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b1, 1'b0, F_PGW,  1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUNL, 1'b1, 13'h0000));
    // Zero-length burst
    vq.push_back(mk(1'b1, 13'h077, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_DONE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_DONE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    // Single beat at last column: no page wait
    vq.push_back(mk(1'b1, 13'h0FF, 8'd1, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUNL, 1'b1, 13'h0FF));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_DONE, 1'b0, 13'h0));
    // colbits=01: 0x0FF is not a boundary
    vq.push_back(mk(1'b1, 13'h0FF, 8'd2, 2'b01, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h0FF));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUNL, 1'b1, 13'h100));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_DONE, 1'b0, 13'h0));
    // colbits=01: 0x1FF is a boundary; stall on beat_ready after ack
    vq.push_back(mk(1'b1, 13'h1FF, 8'd2, 2'b01, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h1FF));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_PGW,  1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b1, 1'b0, F_PGW,  1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_RUNL, 1'b1, 13'h200));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUNL, 1'b1, 13'h200));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_DONE, 1'b0, 13'h0));
    // Abort with accept is ignored; abort in PGWAIT (colbits=10)
    vq.push_back(mk(1'b1, 13'h3FE, 8'd3, 2'b10, 1'b0, 1'b0, 1'b1, F_IDLE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h3FE));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b1, 1'b0, 1'b0, F_RUN,  1'b1, 13'h3FF));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b1, F_PGW,  1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_DONE, 1'b0, 13'h0));
    vq.push_back(mk(1'b0, 13'h000, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));

    foreach (vq[i]) begin
      @(negedge clk);
      chk($sformatf("vec%0d flags", i),
          {26'd0, req_ready, beat_valid, beat_last, pg_req, busy, done}, {26'd0, vq[i].ef});
      if (vq[i].ca) chk($sformatf("vec%0d addr", i), {19'd0, beat_addr}, {19'd0, vq[i].ea});
      drive(vq[i]);
    end

    // len=6, beat_ready toggling, abort after the 3rd transfer
    @(negedge clk);
    drive(mk(1'b1, 13'h040, 8'd6, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    @(negedge clk);
    req_valid = 1'b0;
    xfer_cnt = 0;
    done_cnt = 0;
    ph = 1'b1;
    cyc = 0;
    while (xfer_cnt < 3 && cyc < 40) begin
      beat_ready = ph;
      ph = ~ph;
      @(negedge clk);
      cyc++;
    end
    chk("abort xfer wait bound", {31'd0, (cyc < 40)}, 32'd1);
    abort = 1'b1;
    beat_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort flags", {26'd0, req_ready, beat_valid, beat_last, pg_req, busy, done},
        {26'd0, F_DONE});
    @(negedge clk);
    chk("abort after flags", {26'd0, req_ready, beat_valid, beat_last, pg_req, busy, done},
        {26'd0, F_IDLE});
    chk("abort xfer count", xfer_cnt, 32'd3);
    chk("abort done count", done_cnt, 32'd1);

    // Async reset mid-RUN, then a single-beat burst
    drive(mk(1'b1, 13'h050, 8'd8, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset run", {31'd0, beat_valid}, 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset flags", {26'd0, req_ready, beat_valid, beat_last, pg_req, busy, done},
        {26'd0, F_IDLE});
    chk("async reset addr", {19'd0, beat_addr}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(mk(1'b1, 13'h020, 8'd1, 2'b00, 1'b0, 1'b0, 1'b0, F_IDLE, 1'b0, 13'h0));
    @(negedge clk);
    req_valid = 1'b0;
    beat_ready = 1'b1;
    chk("post-reset flags", {26'd0, req_ready, beat_valid, beat_last, pg_req, busy, done},
        {26'd0, F_RUNL});
    chk("post-reset addr", {19'd0, beat_addr}, 32'h020);
    @(negedge clk);
    beat_ready = 1'b0;
    chk("post-reset done", {26'd0, req_ready, beat_valid, beat_last, pg_req, busy, done},
        {26'd0, F_DONE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
